// File: rtl/harq_send_reader.sv
// HARQ ping/pong buffer read-out: walks the idle buffer, saturates
// each 10-bit soft sum to SAT_W bits and streams it under valid/ready.
module harq_send_reader #(
  parameter int SAT_W = 8,
  parameter int LANES = 16
) (
  input  logic                   i_core_clk,
  input  logic                   i_rx_rstn,
  input  logic                   i_rx_fsm_rstn,
  input  logic                   i_SENDHARQ_Data_request,
  input  logic                   i_SENDHARQ_Data_PingPong_Indicator,
  input  logic [15:0]            i_SENDHARQ_Data_ncb,
  output logic [10:0]            o_SENDHARQ_Data_Address,
  input  logic [LANES*10-1:0]    i_Ping_Read_Data,
  input  logic [LANES*10-1:0]    i_Pong_Read_Data,
  output logic                   o_HARQ_Data_Valid,
  output logic [LANES*SAT_W-1:0] o_HARQ_Data,
  output logic                   o_HARQ_Data_Last,
  input  logic                   i_HARQ_Data_Ready,
  output logic                   o_SENDHARQ_Data_Comp
);

  localparam int DW = LANES*SAT_W;

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [10:0]   addr;
  logic [10:0]   last_addr;
  logic          ind;
  logic          rd_v;
  logic          rd_last;
  logic [DW-1:0] mem [2];
  logic [1:0]    mem_last;
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;
  logic [2:0]    occ;
  logic          pop;
  logic          issue;
  logic          issue_last;
  logic [LANES*10-1:0] sel_q;
  logic [DW-1:0] sat_q;

  function automatic logic [SAT_W-1:0] sat(input logic [9:0] s);
    logic [SAT_W-1:0] r;
    unique case (1'b1)
      (!s[9] && (|s[8:SAT_W-1])):  r = {1'b0, {(SAT_W-1){1'b1}}};
      (s[9] && !(&s[8:SAT_W-1])):  r = {1'b1, {(SAT_W-1){1'b0}}};
      default:                     r = s[SAT_W-1:0];
    endcase
    return r;
  endfunction

  assign pop = (cnt != 2'd0) && i_HARQ_Data_Ready;
  // occupancy the next write will see if nothing pops meanwhile
  assign occ = {1'b0, cnt} + {2'b00, rd_v} - {2'b00, pop};
  assign issue = (state == READ) && (occ < 3'd2);
  assign issue_last = issue && (addr == last_addr);

  assign sel_q = ind ? i_Ping_Read_Data : i_Pong_Read_Data;

  always_comb begin
    sat_q = '0;
    for (int i = 0; i < LANES; i++)
      sat_q[i*SAT_W +: SAT_W] = sat(sel_q[i*10 +: 10]);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (i_SENDHARQ_Data_request) state_nx = READ;
      READ:  if (issue_last) state_nx = DRAIN;
      DRAIN: if (pop && mem_last[rp]) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn)          state <= IDLE;
    else if (!i_rx_fsm_rstn) state <= IDLE;
    else                     state <= state_nx;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      addr      <= '0;
      last_addr <= '0;
      ind       <= 1'b0;
      rd_v      <= 1'b0;
      rd_last   <= 1'b0;
    end else if (!i_rx_fsm_rstn) begin
      addr    <= '0;
      rd_v    <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_v    <= issue;
      rd_last <= issue_last;
      if (state == IDLE && i_SENDHARQ_Data_request) begin
        last_addr <= i_SENDHARQ_Data_ncb[15] ? 11'h7FF
                                             : i_SENDHARQ_Data_ncb[14:4];
        ind       <= i_SENDHARQ_Data_PingPong_Indicator;
        addr      <= '0;
      end else if (issue && !issue_last) begin
        addr <= addr + 11'd1;
      end else if (state == DONE) begin
        addr <= '0;
      end
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      mem_last <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= '0;
    end else if (!i_rx_fsm_rstn) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (rd_v) begin
        mem[wp]      <= sat_q;
        mem_last[wp] <= rd_last;
        wp           <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, rd_v} - {1'b0, pop};
    end
  end

  assign o_SENDHARQ_Data_Address = addr;
  assign o_HARQ_Data_Valid       = (cnt != 2'd0);
  assign o_HARQ_Data             = mem[rp];
  assign o_HARQ_Data_Last        = (cnt != 2'd0) && mem_last[rp];
  assign o_SENDHARQ_Data_Comp    = (state == DONE);

endmodule
